// File: rtl/ext_mem_pkg.sv
// Shared types and defaults for the wait-state external data memory.
package ext_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam logic [31:0] IDLE_DATA_DEF = 32'hFA11_1EAF;
   localparam logic [31:0] OOR_DATA_DEF  = 32'hDEAD_BEEF;

   function automatic int lsb(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/ext_mem_bank.sv
// Byte-lane-enabled synchronous RAM, one write port, one registered read port.
module ext_mem_bank #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = 12
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic                re_i,
   input  logic [AW-1:0]       addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be_i[b]) begin
               r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      if (re_i) begin
         r_rdata <= r_mem[addr_i];
      end
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/ext_mem_wait.sv
// Word-addressed byte-enabled RAM behind a req/ready handshake
// with a configurable number of wait states.
module ext_mem_wait
   import ext_mem_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] IDLE_DATA   = IDLE_DATA_DEF,
   parameter logic [31:0] OOR_DATA    = OOR_DATA_DEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                mem_req_i,
   input  logic                write_enable_i,
   input  logic [DATA_W/8-1:0] byte_enable_i,
   input  logic [31:0]         addr_i,
   input  logic [DATA_W-1:0]   write_data_i,
   output logic [DATA_W-1:0]   read_data_o,
   output logic                ready_o
);

   localparam int NB  = DATA_W / 8;
   localparam int LSB = lsb(DATA_W);
   localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [DATA_W-1:0] IDLE_W = DATA_W'(IDLE_DATA);
   localparam logic [DATA_W-1:0] OOR_W  = DATA_W'(OOR_DATA);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              w_accept;
   logic              w_access;
   logic              r_ready;
   logic              r_rd_valid;
   logic              r_rd_oor;
   logic [31:0]       r_addr;
   logic              r_we;
   logic [NB-1:0]     r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [31:0]       w_addr;
   logic              w_we;
   logic [NB-1:0]     w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [31-LSB:0]   w_idx;
   logic              w_oor;
   logic              w_unused_lsb;
   logic [DATA_W-1:0] w_bank_rdata;

   // LATENCY=0 performs the access on the accepting edge, so live inputs
   // are used outside WAIT; in WAIT the captured request is used.
   assign w_addr  = (r_state == WAIT) ? r_addr  : addr_i;
   assign w_we    = (r_state == WAIT) ? r_we    : write_enable_i;
   assign w_be    = (r_state == WAIT) ? r_be    : byte_enable_i;
   assign w_wdata = (r_state == WAIT) ? r_wdata : write_data_i;

   assign w_idx        = w_addr[31:LSB];
   assign w_oor        = 33'(w_idx) >= 33'(DEPTH_WORDS);
   assign w_unused_lsb = ^w_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_access    = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            w_state_nxt = IDLE;
            if (mem_req_i) begin
               w_accept = 1'b1;
               if (LATENCY == 0) begin
                  w_state_nxt = DONE;
                  w_access    = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = DONE;
               w_access    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_ready    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_oor   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ready    <= (w_state_nxt == DONE);
         r_rd_valid <= w_access & ~w_we & ~w_oor;
         r_rd_oor   <= w_access & ~w_we & w_oor;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_addr  <= addr_i;
         r_we    <= write_enable_i;
         r_be    <= byte_enable_i;
         r_wdata <= write_data_i;
      end
   end

   ext_mem_bank #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_bank (
      .clk_i   (clk_i),
      .we_i    (w_access & w_we & ~w_oor),
      .be_i    (w_be),
      .re_i    (w_access & ~w_we & ~w_oor),
      .addr_i  (w_idx[AW-1:0]),
      .wdata_i (w_wdata),
      .rdata_o (w_bank_rdata)
   );

   assign ready_o     = r_ready;
   assign read_data_o = r_rd_valid ? w_bank_rdata :
                        r_rd_oor   ? OOR_W        : IDLE_W;

endmodule

// File: tb/tb_ext_mem_wait.sv
// Directed bench: LATENCY=2 instance for handshake/data checks,
// LATENCY=0 instance for single-cycle streaming.
module tb_ext_mem_wait;

   localparam logic [31:0] IDLE = 32'hFA11_1EAF;
   localparam logic [31:0] OOR  = 32'hDEAD_BEEF;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [3:0]  be    = 4'h0;
   logic [31:0] addr  = 32'h0;
   logic [31:0] wd    = 32'h0;
   logic        rdy2;
   logic        rdy0;
   logic [31:0] rd2;
   logic [31:0] rd0;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string       nm;
      logic        w;
      logic [3:0]  b;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tv [11];

   always #5 clk = ~clk;

   ext_mem_wait #(
      .DATA_W (32), .DEPTH_WORDS (4096), .LATENCY (2)
   ) dut2 (
      .clk_i (clk), .rst_ni (rst_n), .mem_req_i (req),
      .write_enable_i (we), .byte_enable_i (be), .addr_i (addr),
      .write_data_i (wd), .read_data_o (rd2), .ready_o (rdy2)
   );

   ext_mem_wait #(
      .DATA_W (32), .DEPTH_WORDS (4096), .LATENCY (0)
   ) dut0 (
      .clk_i (clk), .rst_ni (rst_n), .mem_req_i (req),
      .write_enable_i (we), .byte_enable_i (be), .addr_i (addr),
      .write_data_i (wd), .read_data_o (rd0), .ready_o (rdy0)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // One request on dut2 from the current negedge; expects ready
   // on the third negedge afterwards, then checks the data word.
   task automatic acc2(input string nm, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp);
      int k;
      req = 1'b1; we = w; be = b; addr = a; wd = d;
      @(negedge clk);
      req = 1'b0;
      k = 1;
      while (!rdy2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, 32'(k), 32'd3);
      chk({nm, " data"}, rd2, exp);
   endtask

   initial begin
      tv[0]  = '{"wr full",   1'b1, 4'hF, 32'h10,   32'h1234_5678, IDLE};
      tv[1]  = '{"rd full",   1'b0, 4'hF, 32'h10,   32'h0,         32'h1234_5678};
      tv[2]  = '{"wr part",   1'b1, 4'h5, 32'h10,   32'hAABB_CCDD, IDLE};
      tv[3]  = '{"rd part",   1'b0, 4'h0, 32'h10,   32'h0,         32'h12BB_56DD};
      tv[4]  = '{"rd oor",    1'b0, 4'hF, 32'h4000, 32'h0,         OOR};
      tv[5]  = '{"wr 0",      1'b1, 4'hF, 32'h0,    32'h1111_2222, IDLE};
      tv[6]  = '{"wr oor",    1'b1, 4'hF, 32'h4000, 32'h0,         IDLE};
      tv[7]  = '{"rd 0",      1'b0, 4'hF, 32'h0,    32'h0,         32'h1111_2222};
      tv[8]  = '{"wr 20",     1'b1, 4'hF, 32'h20,   32'h5566_7788, IDLE};
      tv[9]  = '{"wr be0",    1'b1, 4'h0, 32'h20,   32'hFFFF_FFFF, IDLE};
      tv[10] = '{"rd 22",     1'b0, 4'h0, 32'h22,   32'h0,         32'h5566_7788};

      repeat (2) @(negedge clk);
      chk("rst rdy2", 32'(rdy2), 32'd0);
      chk("rst rd2", rd2, IDLE);
      chk("rst rdy0", 32'(rdy0), 32'd0);
      chk("rst rd0", rd0, IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         acc2(tv[i].nm, tv[i].w, tv[i].b, tv[i].a, tv[i].d, tv[i].exp);
      end

      // reset while the write is waiting
      req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wd = 32'hCAFE_F00D;
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("wait rst rdy", 32'(rdy2), 32'd0);
      chk("wait rst rd", rd2, IDLE);
      repeat (3) @(negedge clk);
      chk("wait rst hold rdy", 32'(rdy2), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      acc2("rd after abort", 1'b0, 4'hF, 32'h20, 32'h0, 32'h5566_7788);

      // inputs toggling in WAIT must not affect the captured request
      acc2("wr 34", 1'b1, 4'hF, 32'h34, 32'h3434_3434, IDLE);
      req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wd = 32'h0BAD_F00D;
      @(negedge clk);
      we = 1'b0; addr = 32'h34; wd = 32'h1212_1212;
      @(negedge clk);
      req = 1'b0; addr = 32'h38; wd = 32'h7777_7777;
      @(negedge clk);
      chk("toggle rdy", 32'(rdy2), 32'd1);
      chk("toggle rd", rd2, IDLE);
      acc2("rd 30", 1'b0, 4'hF, 32'h30, 32'h0, 32'h0BAD_F00D);
      acc2("rd 34", 1'b0, 4'hF, 32'h34, 32'h0, 32'h3434_3434);

      // LATENCY=0 streaming with req held high
      @(negedge clk);
      req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wd = 32'hA5A5_0001;
      @(negedge clk);
      chk("s0 rdy", 32'(rdy0), 32'd1);
      chk("s0 rd", rd0, IDLE);
      we = 1'b0;
      @(negedge clk);
      chk("s1 rdy", 32'(rdy0), 32'd1);
      chk("s1 rd", rd0, 32'hA5A5_0001);
      we = 1'b1; addr = 32'h44; wd = 32'h5A5A_0002;
      @(negedge clk);
      chk("s2 rdy", 32'(rdy0), 32'd1);
      chk("s2 rd", rd0, IDLE);
      we = 1'b0;
      @(negedge clk);
      chk("s3 rdy", 32'(rdy0), 32'd1);
      chk("s3 rd", rd0, 32'h5A5A_0002);
      req = 1'b0;
      @(negedge clk);
      chk("s4 rdy", 32'(rdy0), 32'd0);
      chk("s4 rd", rd0, IDLE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
